// File: rtl/mul_div_dispatch_pkg.sv
`default_nettype none
// ============================================================================
// Module      : PkgAlu (package)
// Description : Shared op encoding, dispatcher state encoding and constants
//               for the multiply/divide dispatcher.
// Revision    : 1.0 - initial release
// ============================================================================
package PkgAlu;

    // Command op codes; codes 5..7 are not listed and are executed as MUL
    typedef enum logic [2:0] {
        OP_MUL  = 3'd0,
        OP_UDIV = 3'd1,
        OP_SDIV = 3'd2,
        OP_UMOD = 3'd3,
        OP_SMOD = 3'd4
    } alu_op_e;

    // Dispatcher states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESULT = 2'd3
    } disp_state_e;

    // Quotient returned for a divide by zero when the divider is bypassed
    localparam logic [31:0] C_DIV0_QUOT = 32'hFFFF_FFFF;

endpackage : PkgAlu
`default_nettype wire

// File: rtl/mul_div_dispatch_decode.sv
`default_nettype none
// ============================================================================
// Module      : MulDivOpDecode
// Description : Combinational op decode into divider selection, signedness
//               and remainder-select flags.
// Revision    : 1.0 - initial release
// ============================================================================
module MulDivOpDecode
    import PkgAlu::*;
(
    input  logic [2:0] op,
    output logic       is_div,
    output logic       is_signed,
    output logic       want_rem
);

    // Map each op code onto the three control flags; unknown codes run as MUL
    always_comb begin
        is_div    = 1'b0;
        is_signed = 1'b0;
        want_rem  = 1'b0;
        case (op)
            OP_UDIV: is_div = 1'b1;
            OP_SDIV: begin is_div = 1'b1; is_signed = 1'b1; end
            OP_UMOD: begin is_div = 1'b1; want_rem = 1'b1; end
            OP_SMOD: begin is_div = 1'b1; is_signed = 1'b1; want_rem = 1'b1; end
            default: ;
        endcase
    end

endmodule : MulDivOpDecode
`default_nettype wire

// File: rtl/mul_div_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : mul_div_dispatch
// Description : Accepts one MUL/DIV/MOD command at a time, issues it to an
//               external multiplier or divider, waits for the result and
//               presents it for one cycle. Supports flushing a pending op.
//               Optional macro DIV_BY_ZERO_FIXUP_EN: divides by zero bypass
//               the divider and return all-ones quotient / dividend remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module mul_div_dispatch
    import PkgAlu::*;
#(
    parameter int DEST_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_enable,
    input  logic [2:0]            in_op,
    input  logic [31:0]           in_a,
    input  logic [31:0]           in_b,
    input  logic [DEST_WIDTH-1:0] in_dest,
    input  logic                  in_flush,
    output logic                  out_can_accept_cmd,
    output logic                  out_data_ready,
    output logic [31:0]           out_result,
    output logic [DEST_WIDTH-1:0] out_dest,
    output logic                  mul_enable,
    output logic [31:0]           mul_x,
    output logic [31:0]           mul_y,
    input  logic                  mul_can_accept_cmd,
    input  logic                  mul_data_ready,
    input  logic [31:0]           mul_prod,
    output logic                  div_enable,
    output logic                  div_unsgn_or_sgn,
    output logic [31:0]           div_num,
    output logic [31:0]           div_denom,
    input  logic                  div_can_accept_cmd,
    input  logic                  div_data_ready,
    input  logic [31:0]           div_quot,
    input  logic [31:0]           div_rem
);

    disp_state_e           state_q, state_d;
    logic [2:0]            op_q, op_d;
    logic [31:0]           a_q, a_d;
    logic [31:0]           b_q, b_d;
    logic [DEST_WIDTH-1:0] dest_q, dest_d;
    logic                  drop_q, drop_d;
    logic [31:0]           result_q, result_d;
    logic [DEST_WIDTH-1:0] res_dest_q, res_dest_d;

    logic        w_is_div;
    logic        w_is_signed;
    logic        w_want_rem;
    logic        w_bypass;
    logic        w_unit_ready;
    logic [31:0] w_unit_result;

    MulDivOpDecode u_decode (
        .op        (op_q),
        .is_div    (w_is_div),
        .is_signed (w_is_signed),
        .want_rem  (w_want_rem)
    );

`ifdef DIV_BY_ZERO_FIXUP_EN
    assign w_bypass = w_is_div && (b_q == 32'd0);
`else
    assign w_bypass = 1'b0;
`endif

    assign w_unit_ready  = w_is_div ? div_data_ready : mul_data_ready;
    assign w_unit_result = !w_is_div ? mul_prod : (w_want_rem ? div_rem : div_quot);

    assign mul_x            = a_q;
    assign mul_y            = b_q;
    assign div_num          = a_q;
    assign div_denom        = b_q;
    assign div_unsgn_or_sgn = w_is_signed;
    assign out_result       = result_q;
    assign out_dest         = res_dest_q;

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            op_q       <= 3'd0;
            a_q        <= 32'd0;
            b_q        <= 32'd0;
            dest_q     <= '0;
            drop_q     <= 1'b0;
            result_q   <= 32'd0;
            res_dest_q <= '0;
        end else begin
            state_q    <= state_d;
            op_q       <= op_d;
            a_q        <= a_d;
            b_q        <= b_d;
            dest_q     <= dest_d;
            drop_q     <= drop_d;
            result_q   <= result_d;
            res_dest_q <= res_dest_d;
        end
    end

    // Next-state, command capture, drop flag and result capture
    always_comb begin
        state_d    = state_q;
        op_d       = op_q;
        a_d        = a_q;
        b_d        = b_q;
        dest_d     = dest_q;
        drop_d     = drop_q;
        result_d   = result_q;
        res_dest_d = res_dest_q;
        case (state_q)
            ST_IDLE: begin
                if (in_enable) begin
                    op_d    = in_op;
                    a_d     = in_a;
                    b_d     = in_b;
                    dest_d  = in_dest;
                    drop_d  = 1'b0;
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (in_flush) begin
                    state_d = ST_IDLE;
                end else if (w_bypass) begin
                    result_d   = w_want_rem ? a_q : C_DIV0_QUOT;
                    res_dest_d = dest_q;
                    state_d    = ST_RESULT;
                end else if (mul_enable || div_enable) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (in_flush) begin
                    drop_d = 1'b1;
                end
                // A flush arriving with the result still discards it
                if (w_unit_ready) begin
                    if (drop_q || in_flush) begin
                        drop_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        result_d   = w_unit_result;
                        res_dest_d = dest_q;
                        state_d    = ST_RESULT;
                    end
                end
            end
            ST_RESULT: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Handshake outputs; unit enables are gated by the unit's readiness
    always_comb begin
        out_can_accept_cmd = (state_q == ST_IDLE);
        out_data_ready     = (state_q == ST_RESULT) && !in_flush;
        mul_enable         = 1'b0;
        div_enable         = 1'b0;
        if ((state_q == ST_ISSUE) && !in_flush && !w_bypass) begin
            if (w_is_div) begin
                div_enable = div_can_accept_cmd;
            end else begin
                mul_enable = mul_can_accept_cmd;
            end
        end
    end

endmodule : mul_div_dispatch
`default_nettype wire

// File: tb/tb_mul_div_dispatch.sv
`default_nettype none
// ============================================================================
// Module      : tb_mul_div_dispatch
// Description : Directed self-checking bench for mul_div_dispatch with
//               behavioural multiplier (2-cycle) and divider (4-cycle) models.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mul_div_dispatch;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_enable, in_flush;
    logic [2:0]  in_op;
    logic [31:0] in_a, in_b;
    logic [3:0]  in_dest;
    logic        out_can_accept_cmd, out_data_ready;
    logic [31:0] out_result;
    logic [3:0]  out_dest;
    logic        mul_enable, mul_can_accept_cmd, mul_data_ready;
    logic [31:0] mul_x, mul_y, mul_prod;
    logic        div_enable, div_unsgn_or_sgn, div_can_accept_cmd, div_data_ready;
    logic [31:0] div_num, div_denom, div_quot, div_rem;

    int n_cmp  = 0;
    int n_fail = 0;
    int mul_cnt = 0;
    int div_cnt = 0;

    mul_div_dispatch #(.DEST_WIDTH(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_enable(in_enable), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .in_dest(in_dest), .in_flush(in_flush),
        .out_can_accept_cmd(out_can_accept_cmd), .out_data_ready(out_data_ready),
        .out_result(out_result), .out_dest(out_dest),
        .mul_enable(mul_enable), .mul_x(mul_x), .mul_y(mul_y),
        .mul_can_accept_cmd(mul_can_accept_cmd), .mul_data_ready(mul_data_ready),
        .mul_prod(mul_prod),
        .div_enable(div_enable), .div_unsgn_or_sgn(div_unsgn_or_sgn),
        .div_num(div_num), .div_denom(div_denom),
        .div_can_accept_cmd(div_can_accept_cmd), .div_data_ready(div_data_ready),
        .div_quot(div_quot), .div_rem(div_rem)
    );

    always #5 clk = ~clk;

    // Multiplier model: result pulse two cycles after acceptance; not reset by rst_n
    assign mul_can_accept_cmd = (mul_cnt == 0) && !mul_data_ready;
    always @(posedge clk) begin
        mul_data_ready <= (mul_cnt == 1);
        if (mul_enable && mul_can_accept_cmd) begin
            mul_cnt  <= 2;
            mul_prod <= mul_x * mul_y;
        end else if (mul_cnt > 0) begin
            mul_cnt <= mul_cnt - 1;
        end
    end

    // Divider model: result pulse four cycles after acceptance; not reset by rst_n
    assign div_can_accept_cmd = (div_cnt == 0) && !div_data_ready;
    always @(posedge clk) begin
        div_data_ready <= (div_cnt == 1);
        if (div_enable && div_can_accept_cmd) begin
            div_cnt <= 4;
            if (div_denom == 32'd0) begin
                div_quot <= 32'd0;
                div_rem  <= 32'd0;
            end else if (div_unsgn_or_sgn) begin
                div_quot <= 32'($signed(div_num) / $signed(div_denom));
                div_rem  <= 32'($signed(div_num) % $signed(div_denom));
            end else begin
                div_quot <= div_num / div_denom;
                div_rem  <= div_num % div_denom;
            end
        end else if (div_cnt > 0) begin
            div_cnt <= div_cnt - 1;
        end
    end

    // Drive one command and observe the DUT for a fixed window of cycles
    task automatic do_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] dest, output int pulses, output logic [31:0] res,
                          output logic [3:0] dst, output logic cac_bad, output logic gate_bad,
                          output logic both_bad, output int mul_en_cyc, output int div_en_cyc,
                          output logic sgn, output int held);
        pulses = 0; res = '0; dst = '0; cac_bad = 0; gate_bad = 0; both_bad = 0;
        mul_en_cyc = 0; div_en_cyc = 0; sgn = 0; held = 0;
        @(negedge clk);
        in_enable = 1; in_op = op; in_a = a; in_b = b; in_dest = dest;
        @(negedge clk);
        in_enable = 0;
        for (int i = 0; i < 14; i++) begin
            if (mul_enable && div_enable) both_bad = 1;
            if ((mul_enable && !mul_can_accept_cmd) || (div_enable && !div_can_accept_cmd)) gate_bad = 1;
            if (pulses == 0 && mul_en_cyc == 0 && div_en_cyc == 0 && !out_can_accept_cmd
                && !div_can_accept_cmd && !div_enable) held++;
            if (mul_enable) mul_en_cyc++;
            if (div_enable) begin div_en_cyc++; sgn = div_unsgn_or_sgn; end
            if (pulses == 0 && !out_data_ready && out_can_accept_cmd) cac_bad = 1;
            if (out_data_ready) begin pulses++; res = out_result; dst = out_dest; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        #12;
        n_cmp++; if (out_can_accept_cmd !== 1'b1) begin n_fail++; $display("FAIL reset_cac: got %b want 1", out_can_accept_cmd); end
        n_cmp++; if (out_data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b want 0", out_data_ready); end
        n_cmp++; if (out_result !== 32'd0) begin n_fail++; $display("FAIL reset_result: got %h want 0", out_result); end
        n_cmp++; if (out_dest !== 4'd0) begin n_fail++; $display("FAIL reset_dest: got %h want 0", out_dest); end
        n_cmp++; if ({mul_enable, div_enable} !== 2'b00) begin n_fail++; $display("FAIL reset_en: got %b want 00", {mul_enable, div_enable}); end
        @(negedge clk); rst_n = 1;
    endtask

    task automatic test_mul();
        int p, me, de, h; logic [31:0] r; logic [3:0] d; logic cb, gb, bb, s;
        do_cmd(3'd0, 32'd7, 32'd6, 4'd5, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1) begin n_fail++; $display("FAIL mul_pulses: got %0d want 1", p); end
        n_cmp++; if (r !== 32'd42) begin n_fail++; $display("FAIL mul_result: got %h want 2a", r); end
        n_cmp++; if (d !== 4'd5) begin n_fail++; $display("FAIL mul_dest: got %h want 5", d); end
        n_cmp++; if (cb !== 1'b0) begin n_fail++; $display("FAIL mul_cac_low: got %b want 0", cb); end
        n_cmp++; if (me !== 1 || de !== 0 || bb !== 1'b0) begin n_fail++; $display("FAIL mul_enables: got mul %0d div %0d both %b want 1 0 0", me, de, bb); end
        n_cmp++; if (out_result !== 32'd42) begin n_fail++; $display("FAIL mul_hold: got %h want 2a", out_result); end
        // Op code 7 runs as MUL
        do_cmd(3'd7, 32'd4, 32'd5, 4'd2, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'd20 || me !== 1 || de !== 0) begin n_fail++; $display("FAIL op7_mul: got p %0d r %h mul %0d div %0d want 1 14 1 0", p, r, me, de); end
    endtask

    task automatic test_div();
        int p, me, de, h; logic [31:0] r; logic [3:0] d; logic cb, gb, bb, s;
        do_cmd(3'd2, 32'hFFFF_FFF9, 32'd2, 4'd3, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'hFFFF_FFFD) begin n_fail++; $display("FAIL sdiv_result: got p %0d r %h want 1 fffffffd", p, r); end
        n_cmp++; if (s !== 1'b1 || de !== 1 || me !== 0) begin n_fail++; $display("FAIL sdiv_issue: got sgn %b div %0d mul %0d want 1 1 0", s, de, me); end
        do_cmd(3'd4, 32'hFFFF_FFF9, 32'd2, 4'd4, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'hFFFF_FFFF || s !== 1'b1) begin n_fail++; $display("FAIL smod_result: got p %0d r %h sgn %b want 1 ffffffff 1", p, r, s); end
        do_cmd(3'd1, 32'hFFFF_FFFF, 32'd16, 4'd6, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'h0FFF_FFFF || d !== 4'd6) begin n_fail++; $display("FAIL udiv_result: got p %0d r %h d %h want 1 0fffffff 6", p, r, d); end
        n_cmp++; if (s !== 1'b0 || cb !== 1'b0) begin n_fail++; $display("FAIL udiv_sgn: got sgn %b cac_bad %b want 0 0", s, cb); end
        do_cmd(3'd3, 32'd17, 32'd5, 4'd7, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'd2 || s !== 1'b0) begin n_fail++; $display("FAIL umod_result: got p %0d r %h sgn %b want 1 2 0", p, r, s); end
    endtask

    task automatic test_flush_wait();
        int pulses = 0; logic seen = 0; logic bad = 0;
        @(negedge clk);
        in_enable = 1; in_op = 3'd0; in_a = 32'd3; in_b = 32'd3; in_dest = 4'd1;
        @(negedge clk);
        in_enable = 0;
        n_cmp++; if (mul_enable !== 1'b1) begin n_fail++; $display("FAIL flush_issue: got mul_enable %b want 1", mul_enable); end
        @(negedge clk);
        in_flush = 1;
        @(negedge clk);
        in_flush = 0;
        for (int i = 0; i < 10; i++) begin
            if (mul_data_ready) seen = 1;
            if (out_can_accept_cmd && !seen) bad = 1;
            if (out_data_ready) pulses++;
            @(negedge clk);
        end
        n_cmp++; if (pulses !== 0) begin n_fail++; $display("FAIL flush_no_ready: got %0d pulses want 0", pulses); end
        n_cmp++; if (bad !== 1'b0 || seen !== 1'b1) begin n_fail++; $display("FAIL flush_accept_order: got early %b seen %b want 0 1", bad, seen); end
        n_cmp++; if (out_can_accept_cmd !== 1'b1 || out_result !== 32'd2) begin n_fail++; $display("FAIL flush_idle: got cac %b result %h want 1 2", out_can_accept_cmd, out_result); end
    endtask

    task automatic test_reset_mid_wait();
        int p, me, de, h; logic [31:0] r; logic [3:0] d; logic cb, gb, bb, s;
        @(negedge clk);
        in_enable = 1; in_op = 3'd1; in_a = 32'd100; in_b = 32'd7; in_dest = 4'd8;
        @(negedge clk);
        in_enable = 0;
        n_cmp++; if (div_enable !== 1'b1) begin n_fail++; $display("FAIL rst_issue: got div_enable %b want 1", div_enable); end
        @(negedge clk);
        n_cmp++; if (out_can_accept_cmd !== 1'b0 || div_enable !== 1'b0) begin n_fail++; $display("FAIL rst_in_wait: got cac %b div_en %b want 0 0", out_can_accept_cmd, div_enable); end
        rst_n = 0;
        #1;
        n_cmp++; if ({out_can_accept_cmd, out_data_ready, mul_enable, div_enable} !== 4'b1000) begin n_fail++; $display("FAIL rst_async_ctl: got %b want 1000", {out_can_accept_cmd, out_data_ready, mul_enable, div_enable}); end
        n_cmp++; if (out_result !== 32'd0 || out_dest !== 4'd0) begin n_fail++; $display("FAIL rst_async_data: got %h %h want 0 0", out_result, out_dest); end
        @(negedge clk);
        rst_n = 1;
        do_cmd(3'd1, 32'd20, 32'd3, 4'd9, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (gb !== 1'b0 || h < 1) begin n_fail++; $display("FAIL rst_gating: got gate_bad %b held %0d want 0 >=1", gb, h); end
        n_cmp++; if (p !== 1 || r !== 32'd6 || d !== 4'd9) begin n_fail++; $display("FAIL rst_next_udiv: got p %0d r %h d %h want 1 6 9", p, r, d); end
    endtask

`ifdef DIV_BY_ZERO_FIXUP_EN
    task automatic test_div_zero();
        int p, me, de, h; logic [31:0] r; logic [3:0] d; logic cb, gb, bb, s;
        do_cmd(3'd1, 32'd5, 32'd0, 4'd10, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'hFFFF_FFFF || de !== 0) begin n_fail++; $display("FAIL div0_udiv: got p %0d r %h div_en %0d want 1 ffffffff 0", p, r, de); end
        do_cmd(3'd3, 32'd5, 32'd0, 4'd11, p, r, d, cb, gb, bb, me, de, s, h);
        n_cmp++; if (p !== 1 || r !== 32'd5 || de !== 0 || d !== 4'd11) begin n_fail++; $display("FAIL div0_umod: got p %0d r %h div_en %0d d %h want 1 5 0 b", p, r, de, d); end
    endtask
`endif

    initial begin
        rst_n = 0; in_enable = 0; in_flush = 0; in_op = 0; in_a = 0; in_b = 0; in_dest = 0;
        mul_data_ready = 0; mul_prod = 0; div_data_ready = 0; div_quot = 0; div_rem = 0;
        test_reset();
        test_mul();
        test_div();
        test_flush_wait();
        test_reset_mid_wait();
`ifdef DIV_BY_ZERO_FIXUP_EN
        test_div_zero();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_mul_div_dispatch
`default_nettype wire

// File: doc/mul_div_dispatch.md
MUL_DIV_DISPATCH -- requirements
Module: mul_div_dispatch

Interface
REQ-001 SHALL have parameter DEST_WIDTH, default 4, destination register index width.
REQ-002 SHALL have port clk  in  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port rst_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports in_enable  in  1, in_op  in  3, in_a/in_b  in  32 each, in_dest  in  DEST_WIDTH; these form the pipeline command.
REQ-005 SHALL have port in_flush  in  1  discard any pending result.
REQ-006 SHALL have ports out_can_accept_cmd  out  1, out_data_ready  out  1, out_result  out  32, out_dest  out  DEST_WIDTH.
REQ-007 SHALL have ports mul_enable  out  1, mul_x/mul_y  out  32, mul_can_accept_cmd/mul_data_ready  in  1, mul_prod  in  32.
REQ-008 SHALL have ports div_enable/div_unsgn_or_sgn  out  1, div_num/div_denom  out  32, div_can_accept_cmd/div_data_ready  in  1, div_quot/div_rem  in  32.

Function
REQ-009 SHALL decode in_op as: 0 MUL, 1 UDIV, 2 SDIV, 3 UMOD, 4 SMOD; codes 5-7 are treated as MUL.
REQ-010 SHALL implement states IDLE, ISSUE, WAIT, RESULT.
REQ-011 In IDLE, SHALL hold out_can_accept_cmd=1.
REQ-012 In IDLE, in_enable=1 SHALL register op, a, b and dest, and the state SHALL go to ISSUE.
REQ-013 In all states other than IDLE, SHALL hold out_can_accept_cmd=0 and ignore in_enable.
REQ-014 In ISSUE, SHALL assert the selected unit's enable only while that unit's can_accept_cmd=1.
REQ-015 ISSUE SHALL go to WAIT on the edge where enable and can_accept_cmd are both 1.
REQ-016 In WAIT, a selected-unit data_ready=1 SHALL capture the result and move to RESULT.
REQ-017 Result SHALL be mul_prod for MUL, div_quot for UDIV/SDIV, div_rem for UMOD/SMOD.
REQ-018 In RESULT, SHALL drive out_data_ready=1 for exactly one cycle with out_result/out_dest valid, then return to IDLE.
REQ-019 out_result and out_dest SHALL hold their values until the next RESULT.
REQ-020 SHALL drive div_unsgn_or_sgn=1 for SDIV/SMOD and 0 otherwise.
REQ-021 SHALL drive mul_x=a, mul_y=b, div_num=a, div_denom=b from registered operands, unmodified, 32-bit.
REQ-022 SHALL never assert mul_enable and div_enable in the same cycle.
REQ-023 in_flush=1 in ISSUE SHALL return the state to IDLE with no unit enabled.
REQ-024 in_flush=1 in WAIT SHALL set a drop flag; the state still waits for data_ready, then goes to IDLE without RESULT.
REQ-025 in_flush=1 in RESULT SHALL suppress out_data_ready for that cycle.
REQ-026 in_flush in IDLE SHALL have no effect.
REQ-027 in_flush and in_enable asserted together in IDLE SHALL accept the command.

Reset
REQ-028 rst_n=0 SHALL immediately force IDLE, out_can_accept_cmd=1, out_data_ready=0, out_result=0, out_dest=0, mul_enable=0, div_enable=0, and clear the drop flag.
REQ-029 After reset mid-operation, the unit's can_accept_cmd gating in ISSUE SHALL prevent issuing to a unit that is still busy.

Configuration
REQ-030 With DIV_BY_ZERO_FIXUP_EN defined, a divide op with b=0 SHALL bypass the divider: ISSUE goes directly to RESULT with quotient 32'hFFFF_FFFF or remainder = a.
REQ-031 Without DIV_BY_ZERO_FIXUP_EN, b=0 SHALL be issued to the divider normally, and the result is the divider's unspecified output.

Structure
REQ-032 The op encoding enum and the state enum SHALL live in shared package PkgAlu.
REQ-033 SHALL contain one sub-module, MulDivOpDecode (combinational op to {is_div, is_signed, want_rem}).

Verification
REQ-034 Bench SHALL cover: MUL a=7, b=6 with a 2-cycle multiplier model -> one out_data_ready pulse, out_result=42, out_dest echoed, out_can_accept_cmd low throughout.
REQ-035 Bench SHALL cover: SDIV a=-7, b=2 -> out_result=32'hFFFF_FFFD; SMOD same operands -> 32'hFFFF_FFFF; div_unsgn_or_sgn=1 during the issue.
REQ-036 Bench SHALL cover: UDIV a=32'hFFFF_FFFF, b=16 -> 32'h0FFF_FFFF, with div_unsgn_or_sgn=0.
REQ-037 Bench SHALL cover: in_flush during WAIT of MUL 3*3 -> no out_data_ready; the next command is accepted only after mul_data_ready.
REQ-038 Bench SHALL cover: rst_n low during WAIT, with the divider model still busy -> outputs at reset values at once; the next UDIV is held in ISSUE until div_can_accept_cmd=1.
REQ-039 Bench SHALL cover, with DIV_BY_ZERO_FIXUP_EN: UDIV 5/0 -> 32'hFFFF_FFFF with div_enable never asserted; UMOD 5/0 -> 5.
